// File: rtl/riscv_pkg.sv
// riscv_pkg: shared width and the owner/state enums for the memory port arbiter
package riscv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS, OWN_DBG} mem_owner_e;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RSP} arb_state_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select, DBG > LS > IF with IF promoted over LS when starved
module mem_arb_pick
  import riscv_pkg::*;
(
  input  logic       if_req_i,
  input  logic       ls_req_i,
  input  logic       dbg_req_i,
  input  logic       starve_i,
  output mem_owner_e win_o
);
  always_comb
    win_o = dbg_req_i ? OWN_DBG :
            (if_req_i && starve_i) ? OWN_IF :
            ls_req_i ? OWN_LS :
            if_req_i ? OWN_IF : OWN_NONE;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding memory port shared by IF, LS and, with MEM_ARB_DBG_EN, a debug read port
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [3:0]      ls_be_i,
  input  logic [XLEN-1:0] ls_addr_i,
  input  logic [XLEN-1:0] ls_wdata_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [XLEN-1:0] ls_rdata_o,
`ifdef MEM_ARB_DBG_EN
  input  logic            dbg_req_i,
  input  logic [XLEN-1:0] dbg_addr_i,
  output logic            dbg_gnt_o,
  output logic            dbg_rvalid_o,
  output logic [XLEN-1:0] dbg_rdata_o,
`endif
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            busy_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  arb_state_e state_q, state_d;
  mem_owner_e owner_q, owner_d, win, cur;
  logic [SW-1:0] starve_q, starve_d;
  logic dbg_req, gnt, rsp;
  logic [XLEN-1:0] dbg_addr;
`ifdef MEM_ARB_DBG_EN
  assign dbg_req      = dbg_req_i;
  assign dbg_addr     = dbg_addr_i;
  assign dbg_gnt_o    = gnt && cur == OWN_DBG;
  assign dbg_rvalid_o = rsp && owner_q == OWN_DBG;
  assign dbg_rdata_o  = owner_q == OWN_DBG ? mem_rdata_i : '0;
`else
  assign dbg_req  = 1'b0;
  assign dbg_addr = '0;
`endif
  mem_arb_pick u_pick (
    .if_req_i  (if_req_i),
    .ls_req_i  (ls_req_i),
    .dbg_req_i (dbg_req),
    .starve_i  (STARVE_LIMIT != 0 && starve_q == LIM),
    .win_o     (win)
  );
  always_comb begin
    cur         = state_q == ARB_IDLE ? win : owner_q;
    mem_req_o   = state_q == ARB_REQ || (state_q == ARB_IDLE && win != OWN_NONE);
    mem_we_o    = mem_req_o && cur == OWN_LS && ls_we_i;
    mem_be_o    = !mem_req_o ? 4'h0 : cur == OWN_LS ? ls_be_i : 4'hF;
    mem_addr_o  = !mem_req_o ? '0 : cur == OWN_LS ? ls_addr_i : cur == OWN_IF ? if_addr_i : dbg_addr;
    mem_wdata_o = mem_req_o && cur == OWN_LS ? ls_wdata_i : '0;
    gnt         = mem_gnt_i && mem_req_o;
    rsp         = mem_rvalid_i && state_q == ARB_RSP;
    if_gnt_o    = gnt && cur == OWN_IF;
    ls_gnt_o    = gnt && cur == OWN_LS;
    if_rvalid_o = rsp && owner_q == OWN_IF;
    ls_rvalid_o = rsp && owner_q == OWN_LS;
    if_rdata_o  = owner_q == OWN_IF ? mem_rdata_i : '0;
    ls_rdata_o  = owner_q == OWN_LS ? mem_rdata_i : '0;
    busy_o      = state_q != ARB_IDLE;
    state_d     = state_q == ARB_IDLE ? (win == OWN_NONE ? ARB_IDLE : gnt ? ARB_RSP : ARB_REQ) :
                  state_q == ARB_REQ  ? (gnt ? ARB_RSP : ARB_REQ) :
                  mem_rvalid_i ? ARB_IDLE : ARB_RSP;
    owner_d     = state_q == ARB_IDLE ? win : state_d == ARB_IDLE ? OWN_NONE : owner_q;
    starve_d    = if_gnt_o ? '0 : (if_req_i && starve_q != LIM) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed checks of the arbiter against a transaction-level model
module tb_mem_port_arbiter;
  import riscv_pkg::*;
  localparam int LIM = 8;
  logic clk = 1'b0;
  logic rst;
  logic if_req, ls_req, ls_we, mem_gnt, mem_rvalid;
  logic [3:0] ls_be, mem_be;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_DBG_EN
  logic dbg_req, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_rdata;
`endif
  int total = 0, bad = 0;
  bit m_busy, m_gnt, stale;
  int m_own, m_starve;
  int rsp_wait = -1;
  logic [31:0] rsp_data;
  logic [31:0] mem [logic [31:0]];
  always #5 clk = ~clk;
  mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
`ifdef MEM_ARB_DBG_EN
    .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
`endif
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : a ^ 32'h5a5a_1234;
  endfunction
  task automatic do_reset();
    stale = rsp_wait >= 0 || (m_busy && m_gnt);
    rst = 1; if_req = 0; ls_req = 0; mem_gnt = 0; mem_rvalid = 0;
    @(posedge clk); #1;
    rst = 0;
    m_busy = 0; m_gnt = 0; m_own = 0; m_starve = 0; rsp_wait = -1;
  endtask
  task automatic cycle(int p_if, int p_ls, int p_gnt);
    int win, cur;
    int order[$];
    bit er, eig, elg, erv;
    logic [31:0] o;
    if (!if_req && $urandom_range(99) < p_if) begin
      if_req = 1; if_addr = 32'(4 * $urandom_range(15));
    end
    if (!ls_req && $urandom_range(99) < p_ls) begin
      ls_req = 1; ls_we = 1'($urandom_range(1)); ls_be = 4'($urandom);
      ls_addr = 32'(4 * $urandom_range(15)); ls_wdata = $urandom;
    end
    mem_gnt = $urandom_range(99) < p_gnt;
    mem_rvalid = 0; mem_rdata = $urandom;
    if (rsp_wait == 0) begin mem_rvalid = 1; mem_rdata = rsp_data; end
    else if (rsp_wait < 0) mem_rvalid = stale || $urandom_range(7) == 0;
    if (rsp_wait >= 0) rsp_wait--;
    stale = 0;
    #1;
    if (m_starve == LIM) order = '{1, 2}; else order = '{2, 1};
    win = 0;
    foreach (order[i])
      if (win == 0 && ((order[i] == 1 && if_req) || (order[i] == 2 && ls_req))) win = order[i];
    cur = m_busy ? m_own : win;
    er  = m_busy ? !m_gnt : win != 0;
    eig = er && mem_gnt && cur == 1;
    elg = er && mem_gnt && cur == 2;
    erv = mem_rvalid && m_busy && m_gnt;
    check("mem_req", 32'(mem_req), 32'(er));
    check("if_gnt", 32'(if_gnt), 32'(eig));
    check("ls_gnt", 32'(ls_gnt), 32'(elg));
    check("busy", 32'(busy), 32'(m_busy));
    check("if_rvalid", 32'(if_rvalid), 32'(erv && m_own == 1));
    check("ls_rvalid", 32'(ls_rvalid), 32'(erv && m_own == 2));
    if (er) begin
      check("mem_addr", mem_addr, cur == 1 ? if_addr : ls_addr);
      check("mem_we", 32'(mem_we), 32'(cur == 2 && ls_we));
      check("mem_be", 32'(mem_be), 32'(cur == 2 ? ls_be : 4'hF));
      if (cur == 2 && ls_we) check("mem_wdata", mem_wdata, ls_wdata);
    end
    if (erv && m_own == 1) check("if_rdata", if_rdata, mem_rdata);
    if (erv && m_own == 2) check("ls_rdata", ls_rdata, mem_rdata);
    if (er && mem_gnt) begin
      rsp_wait = $urandom_range(2);
      rsp_data = rd(cur == 1 ? if_addr : ls_addr);
      if (cur == 2 && ls_we) begin
        o = rd(ls_addr);
        for (int b = 0; b < 4; b++) if (ls_be[b]) o[8*b +: 8] = ls_wdata[8*b +: 8];
        mem[ls_addr] = o;
      end
    end
    m_starve = eig ? 0 : (if_req && m_starve < LIM) ? m_starve + 1 : m_starve;
    if (!m_busy) begin
      if (win != 0) begin m_busy = 1; m_own = win; m_gnt = mem_gnt; end
    end else if (!m_gnt) m_gnt = mem_gnt;
    else if (mem_rvalid) m_busy = 0;
    @(posedge clk); #1;
    if (eig) if_req = 0;
    if (elg) ls_req = 0;
    if (m_busy && !m_gnt && $urandom_range(15) == 0) begin
      if (m_own == 1) if_req = 0; else ls_req = 0;
    end
  endtask
  initial begin
    rst = 1; if_req = 0; ls_req = 0; ls_we = 0; ls_be = 0; if_addr = 0; ls_addr = 0; ls_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; stale = 0;
    m_busy = 0; m_gnt = 0; m_own = 0; m_starve = 0;
`ifdef MEM_ARB_DBG_EN
    dbg_req = 0; dbg_addr = 0;
`endif
    repeat (2) @(posedge clk);
    #1; rst = 0; #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_gnt", 32'(if_gnt), 0);
    check("rst_if_rdata", if_rdata, 0);
    if_req = 1; if_addr = 32'h8000_0000; mem_gnt = 1; #1;
    check("t1_gnt", 32'(if_gnt), 1);
    check("t1_addr", mem_addr, 32'h8000_0000);
    check("t1_be", 32'(mem_be), 32'hF);
    @(posedge clk); #1;
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h13; #1;
    check("t1_rvalid", 32'(if_rvalid), 1);
    check("t1_rdata", if_rdata, 32'h13);
    @(posedge clk); #1;
    mem_rvalid = 0; #1;
    check("t1_idle", 32'(busy), 0);
    if_req = 1; if_addr = 32'h100; ls_req = 1; ls_we = 1; ls_be = 4'hF; ls_addr = 32'h10;
    ls_wdata = 32'hDEAD_BEEF; mem_gnt = 1; #1;
    check("t2_ls_gnt", 32'(ls_gnt), 1);
    check("t2_if_wait", 32'(if_gnt), 0);
    check("t2_we", 32'(mem_we), 1);
    check("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t2_addr", mem_addr, 32'h10);
    @(posedge clk); #1;
    ls_req = 0; mem_rvalid = 1; #1;
    check("t2_ls_rvalid", 32'(ls_rvalid), 1);
    check("t2_rsp_no_gnt", 32'(if_gnt), 0);
    @(posedge clk); #1;
    mem_rvalid = 0; #1;
    check("t2_if_gnt", 32'(if_gnt), 1);
    check("t2_if_we", 32'(mem_we), 0);
    check("t2_if_addr", mem_addr, 32'h100);
    @(posedge clk); #1;
    if_req = 0; mem_gnt = 0;
    do_reset();
    if_req = 1; if_addr = 32'h4; mem_gnt = 1;
    @(posedge clk); #1;
    if_req = 0; mem_gnt = 0; #1;
    check("t3_in_rsp", 32'(busy), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678; #1;
    check("t3_no_rvalid", 32'(if_rvalid), 0);
    check("t3_busy", 32'(busy), 0);
    check("t3_mem_req", 32'(mem_req), 0);
    @(posedge clk); #1;
    mem_rvalid = 0;
`ifdef MEM_ARB_DBG_EN
    dbg_req = 1; dbg_addr = 32'h4; ls_req = 1; ls_we = 1; ls_addr = 32'h8; mem_gnt = 1; #1;
    check("dbg_gnt", 32'(dbg_gnt), 1);
    check("dbg_ls_wait", 32'(ls_gnt), 0);
    check("dbg_we", 32'(mem_we), 0);
    check("dbg_be", 32'(mem_be), 32'hF);
    check("dbg_addr", mem_addr, 32'h4);
    @(posedge clk); #1;
    dbg_req = 0; ls_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = rd(32'h4); #1;
    check("dbg_rvalid", 32'(dbg_rvalid), 1);
    check("dbg_rdata", dbg_rdata, rd(32'h4));
    @(posedge clk); #1;
    mem_rvalid = 0;
`endif
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(149) == 0) do_reset();
      cycle(40, 40, 60);
    end
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(99) == 0) do_reset();
      cycle(100, 100, 100);
    end
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(149) == 0) do_reset();
      cycle(70, 70, 30);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
